// File: rtl/sigma_delta_dac_ctrl.sv
// rtl/sigma_delta_dac_ctrl.sv - sample scheduler and soft-mute gain ramp for the sigma-delta DAC
module sigma_delta_dac_ctrl #(
  parameter int NBITS      = 2,
  parameter int MBITS      = 16,
  parameter int SAMPLE_DIV = 1134,
  parameter int FIFO_DEPTH = 4,
  parameter int RAMP_LOG2  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   s_valid,
  input  logic [15:0]            s_data,
  output logic                   s_ready,
  output logic [NBITS+MBITS-1:0] dac_din,
  output logic                   sample_tick,
  output logic                   muted,
  output logic                   underrun,
  input  logic                   underrun_clr
);
  localparam int DW = NBITS + MBITS;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = DW + RAMP_LOG2 + 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [GW-1:0] GMAX     = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [GW-1:0] GONE     = GW'(1);

  typedef enum logic [1:0] {MUTED, RAMP_UP, PLAY, RAMP_DOWN} state_t;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick        = (cnt == CNT_LAST);
  assign sample_tick = tick;

  always_ff @(posedge clk) begin
    if (reset || tick) cnt <= '0;
    else               cnt <= cnt + CW'(1);
  end

  logic [15:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [15:0] head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_ready = !full && !reset;
  assign push    = s_valid && s_ready;
  // A push landing on a tick into an empty FIFO is not visible to that tick.
  assign pop     = tick && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  state_t             state;
  logic [GW-1:0]      gain;
  logic signed [15:0] s_held;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MUTED;
      gain   <= '0;
      s_held <= '0;
      muted  <= 1'b1;
    end else if (tick) begin
      // The tick that leaves MUTED already fetches the sample it will play at gain 1.
      if (!empty && (state != MUTED || enable)) s_held <= head;
      case (state)
        MUTED: begin
          if (enable) begin
            state <= RAMP_UP;
            gain  <= GONE;
            muted <= 1'b0;
          end
        end
        RAMP_UP: begin
          if (enable) begin
            gain <= gain + GONE;
            if (gain + GONE == GMAX) state <= PLAY;
          end else if (gain == GONE) begin
            gain  <= '0;
            state <= MUTED;
            muted <= 1'b1;
          end else begin
            gain  <= gain - GONE;
            state <= RAMP_DOWN;
          end
        end
        PLAY: begin
          if (!enable) begin
            gain  <= GMAX - GONE;
            state <= RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (!enable) begin
            gain <= gain - GONE;
            if (gain == GONE) begin
              state <= MUTED;
              muted <= 1'b1;
            end
          end else begin
            gain  <= gain + GONE;
            state <= (gain + GONE == GMAX) ? PLAY : RAMP_UP;
          end
        end
        default: begin
          state <= MUTED;
          gain  <= '0;
          muted <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                    underrun <= 1'b0;
    else if (tick && state != MUTED && empty)     underrun <= 1'b1;
    else if (underrun_clr)                        underrun <= 1'b0;
  end

  logic signed [PW-1:0] held_ext, gain_ext, prod, scaled;

  assign held_ext = {{(PW-16){s_held[15]}}, s_held};
  assign gain_ext = {{(PW-GW){1'b0}}, gain};
  assign prod     = held_ext * gain_ext;
  // Arithmetic shift floors toward -inf; Q1.15 then lines up with the DAC's binary point.
  assign scaled   = prod >>> RAMP_LOG2;

  always_ff @(posedge clk) begin
    if (reset) dac_din <= '0;
    else       dac_din <= DW'(scaled << (MBITS - 15));
  end

endmodule

// File: tb/tb_sigma_delta_dac_ctrl.sv
// tb/tb_sigma_delta_dac_ctrl.sv - directed bench for sigma_delta_dac_ctrl with SAMPLE_DIV=8
module tb_sigma_delta_dac_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'h0000;
  logic        s_ready;
  logic [17:0] dac_din;
  logic        sample_tick;
  logic        muted;
  logic        underrun;
  logic        underrun_clr = 1'b0;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  sigma_delta_dac_ctrl #(
    .NBITS(2), .MBITS(16), .SAMPLE_DIV(8), .FIFO_DEPTH(4), .RAMP_LOG2(6)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .dac_din(dac_din), .sample_tick(sample_tick), .muted(muted),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    cyc = 0;
  endtask

  task automatic wait_tick;
    int n = 0;
    do begin
      step();
      n++;
    end while (!sample_tick && n < 32);
    checks++;
    if (!sample_tick) begin
      $display("FAIL tick_timeout: no sample_tick after %0d cycles, want 1 within 8", n);
      fails++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    step();
    checks++; if (s_ready !== 1'b0) begin $display("FAIL rst_s_ready: got %b want 0", s_ready); fails++; end
    checks++; if (dac_din !== 18'h0) begin $display("FAIL rst_dac: got %h want 00000", dac_din); fails++; end
    checks++; if (muted !== 1'b1) begin $display("FAIL rst_muted: got %b want 1", muted); fails++; end
    checks++; if (underrun !== 1'b0) begin $display("FAIL rst_underrun: got %b want 0", underrun); fails++; end
    checks++; if (sample_tick !== 1'b0) begin $display("FAIL rst_tick: got %b want 0", sample_tick); fails++; end
    reset = 1'b0;
    #1;
    cyc = 0;
    checks++; if (s_ready !== 1'b1) begin $display("FAIL rel_s_ready: got %b want 1", s_ready); fails++; end
  endtask

  task automatic test_ramp_up;
    logic [17:0] exp;
    do_reset();
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h4000;
    for (int k = 1; k <= 64; k++) begin
      wait_tick();
      if (k == 1) begin
        checks++; if (cyc != 7) begin $display("FAIL first_tick_cyc: got %0d want 7", cyc); fails++; end
      end
      if (k == 2) begin
        checks++; if (cyc != 15) begin $display("FAIL second_tick_cyc: got %0d want 15", cyc); fails++; end
      end
      step();
      if (k == 1) begin
        checks++; if (muted !== 1'b0) begin $display("FAIL muted_fall: got %b want 0", muted); fails++; end
        checks++; if (dac_din !== 18'h0) begin $display("FAIL dac_latency: got %h want 00000", dac_din); fails++; end
      end
      step();
      exp = 18'(k * 32'h200);
      checks++;
      if (dac_din !== exp) begin $display("FAIL ramp_up_gain%0d: got %h want %h", k, dac_din, exp); fails++; end
    end
    repeat (16) step();
    checks++; if (dac_din !== 18'h08000) begin $display("FAIL play_steady: got %h want 08000", dac_din); fails++; end
    checks++; if (muted !== 1'b0) begin $display("FAIL play_muted: got %b want 0", muted); fails++; end
    checks++; if (underrun !== 1'b0) begin $display("FAIL play_underrun: got %b want 0", underrun); fails++; end
  endtask

  task automatic test_underrun;
    wait_tick();
    s_valid = 1'b0;
    repeat (3) wait_tick();
    step();
    checks++; if (underrun !== 1'b0) begin $display("FAIL drain_no_underrun: got %b want 0", underrun); fails++; end
    wait_tick();
    step();
    checks++; if (underrun !== 1'b1) begin $display("FAIL underrun_set: got %b want 1", underrun); fails++; end
    step();
    checks++; if (dac_din !== 18'h08000) begin $display("FAIL underrun_hold: got %h want 08000", dac_din); fails++; end
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin $display("FAIL underrun_clr: got %b want 0", underrun); fails++; end
    wait_tick();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b1) begin $display("FAIL set_wins: got %b want 1", underrun); fails++; end
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin $display("FAIL underrun_clr2: got %b want 0", underrun); fails++; end
  endtask

  task automatic test_full_scale;
    s_valid = 1'b1;
    s_data  = 16'h8000;
    step();
    s_valid = 1'b0;
    wait_tick();
    step();
    step();
    checks++; if (dac_din !== 18'h30000) begin $display("FAIL neg_full: got %h want 30000", dac_din); fails++; end
    checks++; if (underrun !== 1'b0) begin $display("FAIL neg_underrun: got %b want 0", underrun); fails++; end
    s_valid = 1'b1;
    s_data  = 16'h7FFF;
    step();
    s_valid = 1'b0;
    wait_tick();
    step();
    step();
    checks++; if (dac_din !== 18'h0FFFE) begin $display("FAIL pos_full: got %h want 0fffe", dac_din); fails++; end
  endtask

  task automatic test_fifo_full;
    do_reset();
    enable  = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'hA000;
    for (int i = 0; i < 4; i++) begin
      step();
      s_data = s_data + 16'h1;
    end
    checks++; if (s_ready !== 1'b0) begin $display("FAIL full_after4: got %b want 0", s_ready); fails++; end
    repeat (3) step();
    checks++; if (sample_tick !== 1'b1) begin $display("FAIL full_tick: got %b want 1", sample_tick); fails++; end
    checks++; if (s_ready !== 1'b0) begin $display("FAIL full_at_tick: got %b want 0", s_ready); fails++; end
    step();
    checks++; if (s_ready !== 1'b1) begin $display("FAIL ready_after_pop: got %b want 1", s_ready); fails++; end
    step();
    s_valid = 1'b0;
    checks++; if (s_ready !== 1'b0) begin $display("FAIL full_after5: got %b want 0", s_ready); fails++; end
  endtask

  task automatic test_ramp_down;
    logic [17:0] exp;
    do_reset();
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h4000;
    repeat (10) wait_tick();
    step();
    enable = 1'b0;
    step();
    checks++; if (dac_din !== 18'h01400) begin $display("FAIL gain10: got %h want 01400", dac_din); fails++; end
    for (int g = 9; g >= 0; g--) begin
      wait_tick();
      step();
      step();
      exp = 18'(g * 32'h200);
      checks++;
      if (dac_din !== exp) begin $display("FAIL ramp_down_gain%0d: got %h want %h", g, dac_din, exp); fails++; end
      checks++;
      if (muted !== (g == 0)) begin $display("FAIL ramp_down_muted%0d: got %b want %b", g, muted, (g == 0)); fails++; end
    end
    s_valid = 1'b0;
    wait_tick();
    step();
    checks++; if (s_ready !== 1'b1) begin $display("FAIL muted_drain: got %b want 1", s_ready); fails++; end
    repeat (5) wait_tick();
    step();
    checks++; if (underrun !== 1'b0) begin $display("FAIL muted_no_underrun: got %b want 0", underrun); fails++; end
    checks++; if (dac_din !== 18'h0) begin $display("FAIL muted_dac: got %h want 00000", dac_din); fails++; end
  endtask

  task automatic test_reset_mid_ramp;
    do_reset();
    enable  = 1'b1;
    s_valid = 1'b0;
    wait_tick();
    wait_tick();
    step();
    checks++; if (underrun !== 1'b1) begin $display("FAIL pre_rst_underrun: got %b want 1", underrun); fails++; end
    s_valid = 1'b1;
    s_data  = 16'h1111;
    repeat (3) begin
      step();
      s_data = s_data + 16'h1111;
    end
    s_valid = 1'b0;
    reset   = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin $display("FAIL mid_rst_s_ready: got %b want 0", s_ready); fails++; end
    step();
    checks++; if (dac_din !== 18'h0) begin $display("FAIL mid_rst_dac: got %h want 00000", dac_din); fails++; end
    checks++; if (muted !== 1'b1) begin $display("FAIL mid_rst_muted: got %b want 1", muted); fails++; end
    checks++; if (underrun !== 1'b0) begin $display("FAIL mid_rst_underrun: got %b want 0", underrun); fails++; end
    reset = 1'b0;
    #1;
    cyc = 0;
    s_valid = 1'b1;
    s_data  = 16'h5555;
    step();
    s_valid = 1'b0;
    checks++; if (s_ready !== 1'b1) begin $display("FAIL mid_rst_fifo_empty: got %b want 1", s_ready); fails++; end
    wait_tick();
    checks++; if (cyc != 7) begin $display("FAIL mid_rst_tick_cyc: got %0d want 7", cyc); fails++; end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_underrun();
    test_full_scale();
    test_fifo_full();
    test_ramp_down();
    test_reset_mid_ramp();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
